// File: rtl/pmp_pkg.sv
// Shared types and constants for the phase-datapath front end.
// Quad-pixel field offsets match the {pixel4,pixel3,pixel2,pixel1} beat layout.
package pmp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        STREAM = 2'd2,
        GAP    = 2'd3
    } sched_state_t;

    localparam int QUAD_W   = 32;
    localparam int PIX1_LSB = 0;
    localparam int PIX2_LSB = 8;
    localparam int PIX3_LSB = 16;
    localparam int PIX4_LSB = 24;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; "fwft" presents the head word combinationally, otherwise
// the read word is registered on rd_en. FIFO_DEPTH must be a power of two >= 2.
module sync_fifo #(
    parameter int    DATA_WIDTH = 8,
    parameter int    FIFO_DEPTH = 8,
    parameter string READ_MODE  = "fwft"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  wr_ok;
    logic                  rd_ok;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign rd_ok = rd_en && !empty;
    // A full FIFO still accepts a write when a read frees the slot in the same cycle.
    assign wr_ok = wr_en && (!full || rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    generate
        if (READ_MODE == "fwft") begin : g_fwft
            assign rd_data = mem[rd_ptr];
        end else begin : g_std
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data <= '0;
                end else if (rd_ok) begin
                    rd_data <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/rel_phase_sched.sv
// Line-granular round-robin scheduler feeding one shared relative-phase datapath.
// state  | meaning
// IDLE   | waiting for enable, a valid channel and a free tag slot
// ARB    | pick next channel, push its tag, clear beat counter
// STREAM | forward the granted channel's beats, enforce line length
// GAP    | one dead cycle after a line, then re-arbitrate or idle
module rel_phase_sched
    import pmp_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int LINE_W    = 640,
    parameter int TAG_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic [NUM_CH-1:0]         s_tvalid_i,
    output logic [NUM_CH-1:0]         s_tready_o,
    input  logic [QUAD_W*NUM_CH-1:0]  s_tdata_i,
    input  logic [NUM_CH-1:0]         s_tlast_i,
    output logic                      dp_vld_o,
    output logic [7:0]                dp_pixel1_o,
    output logic [7:0]                dp_pixel2_o,
    output logic [7:0]                dp_pixel3_o,
    output logic [7:0]                dp_pixel4_o,
    output logic                      dp_tlast_o,
    input  logic                      dp_tlast_i,
    input  logic                      dp_vld_i,
    output logic [ch_w(NUM_CH)-1:0]   res_ch_o,
    output logic                      res_tag_vld_o,
    output logic                      busy_o,
    output logic                      err_len_o,
    output logic                      err_tag_o,
    input  logic                      err_clr_i,
    output logic [15:0]               line_cnt_o
);

    localparam int CH_W = ch_w(NUM_CH);
    localparam int BC_W = $clog2(LINE_W);
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(LINE_W - 1);

    sched_state_t      state, state_nxt;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   pick;
    logic [BC_W-1:0]   beat_cnt;
    logic [CH_W-1:0]   tag_head;
    logic              tag_full;
    logic              tag_empty;
    logic              tag_pop;
    logic              start_ok;
    logic              accept;
    logic              at_last;
    logic              line_end;
    logic              len_bad;
    logic [QUAD_W-1:0] quad;

    assign start_ok = en_i && (|s_tvalid_i) && !tag_full;
    assign accept   = (state == STREAM) && s_tvalid_i[grant];
    assign at_last  = (beat_cnt == LAST_BEAT);
    assign line_end = accept && (s_tlast_i[grant] || at_last);
    // Early tlast and missing tlast are both length violations.
    assign len_bad  = accept && (s_tlast_i[grant] != at_last);
    assign quad     = s_tdata_i[QUAD_W*grant +: QUAD_W];
    assign tag_pop  = dp_vld_i && dp_tlast_i;

    always_comb begin
        logic [CH_W:0] cand;
        logic          found;
        pick  = last_grant;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = {1'b0, last_grant} + (CH_W+1)'(k);
            if (cand >= (CH_W+1)'(NUM_CH)) begin
                cand = cand - (CH_W+1)'(NUM_CH);
            end
            if (!found && s_tvalid_i[cand[CH_W-1:0]]) begin
                pick  = cand[CH_W-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        s_tready_o = '0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = ARB;
                end
            end
            ARB: begin
                state_nxt = STREAM;
            end
            STREAM: begin
                s_tready_o[grant] = 1'b1;
                if (line_end) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                state_nxt = start_ok ? ARB : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            beat_cnt   <= '0;
            line_cnt_o <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB) begin
                grant    <= pick;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (line_end) begin
                last_grant <= grant;
                line_cnt_o <= line_cnt_o + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_vld_o    <= 1'b0;
            dp_tlast_o  <= 1'b0;
            dp_pixel1_o <= '0;
            dp_pixel2_o <= '0;
            dp_pixel3_o <= '0;
            dp_pixel4_o <= '0;
        end else begin
            dp_vld_o   <= accept;
            dp_tlast_o <= line_end;
            if (accept) begin
                dp_pixel1_o <= quad[PIX1_LSB +: 8];
                dp_pixel2_o <= quad[PIX2_LSB +: 8];
                dp_pixel3_o <= quad[PIX3_LSB +: 8];
                dp_pixel4_o <= quad[PIX4_LSB +: 8];
            end
        end
    end

    // A set event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_len_o <= 1'b0;
            err_tag_o <= 1'b0;
        end else begin
            if (len_bad) begin
                err_len_o <= 1'b1;
            end else if (err_clr_i) begin
                err_len_o <= 1'b0;
            end
            if (tag_pop && tag_empty) begin
                err_tag_o <= 1'b1;
            end else if (err_clr_i) begin
                err_tag_o <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .DATA_WIDTH (CH_W),
        .FIFO_DEPTH (TAG_DEPTH),
        .READ_MODE  ("fwft")
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (state == ARB),
        .wr_data (pick),
        .rd_en   (tag_pop),
        .rd_data (tag_head),
        .full    (tag_full),
        .empty   (tag_empty)
    );

    assign res_tag_vld_o = !tag_empty;
    assign res_ch_o      = tag_empty ? '0 : tag_head;
    assign busy_o        = (state != IDLE) || !tag_empty;

endmodule

// File: tb/tb_rel_phase_sched.sv
// Scoreboard bench for rel_phase_sched: directed lines per channel, expected beats
// and result tags queued at stimulus time, checked by independent monitors.
module tb_rel_phase_sched;

    localparam int NCH = 2;
    localparam int LW  = 8;
    localparam int TD  = 2;
    localparam int LAT = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en_i = 1'b0;
    logic [NCH-1:0]    s_tvalid_i = '0;
    logic [NCH-1:0]    s_tready_o;
    logic [32*NCH-1:0] s_tdata_i = '0;
    logic [NCH-1:0]    s_tlast_i = '0;
    logic              dp_vld_o;
    logic [7:0]        dp_pixel1_o, dp_pixel2_o, dp_pixel3_o, dp_pixel4_o;
    logic              dp_tlast_o;
    logic              dp_tlast_i = 1'b0;
    logic              dp_vld_i = 1'b0;
    logic [0:0]        res_ch_o;
    logic              res_tag_vld_o;
    logic              busy_o;
    logic              err_len_o;
    logic              err_tag_o;
    logic              err_clr_i = 1'b0;
    logic [15:0]       line_cnt_o;

    rel_phase_sched #(.NUM_CH(NCH), .LINE_W(LW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i),
        .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
        .s_tdata_i(s_tdata_i), .s_tlast_i(s_tlast_i),
        .dp_vld_o(dp_vld_o), .dp_pixel1_o(dp_pixel1_o), .dp_pixel2_o(dp_pixel2_o),
        .dp_pixel3_o(dp_pixel3_o), .dp_pixel4_o(dp_pixel4_o), .dp_tlast_o(dp_tlast_o),
        .dp_tlast_i(dp_tlast_i), .dp_vld_i(dp_vld_i),
        .res_ch_o(res_ch_o), .res_tag_vld_o(res_tag_vld_o), .busy_o(busy_o),
        .err_len_o(err_len_o), .err_tag_o(err_tag_o), .err_clr_i(err_clr_i),
        .line_cnt_o(line_cnt_o)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_mis = 0;
    beat_t       src_q [NCH][$];
    beat_t       exp_q [$];
    int          tag_q [$];
    logic [NCH-1:0] hs = '0;
    int          pend = 0;
    logic [LAT-1:0] dl = '0;
    logic        hold = 1'b0;
    logic        spur = 1'b0;
    logic        chk_gap = 1'b0;
    logic        gap_armed = 1'b0;
    int          idle_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int ch, input int id, input int b);
        logic [7:0] c8, i8, b8;
        c8 = ch[7:0];
        i8 = id[7:0];
        b8 = b[7:0];
        return {c8, i8, b8, 8'hA5 ^ b8};
    endfunction

    task automatic send_line(input int ch, input int id, input int n, input int last_at);
        for (int b = 0; b < n; b++) src_q[ch].push_back({mk(ch, id, b), b == last_at});
    endtask

    task automatic exp_line(input int ch, input int id, input int b0, input int n);
        for (int b = b0; b < b0 + n; b++) exp_q.push_back({mk(ch, id, b), b == b0 + n - 1});
        tag_q.push_back(ch);
    endtask

    task automatic flush();
        for (int c = 0; c < NCH; c++) src_q[c].delete();
        exp_q.delete();
        tag_q.delete();
        pend = 0;
        dl = '0;
        hold = 1'b0;
        gap_armed = 1'b0;
        chk_gap = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_lines(input int n);
        for (int i = 0; i < 400 && line_cnt_o != 16'(n); i++) @(negedge clk);
        check("line_cnt_reach", 32'(line_cnt_o), 32'(n));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && (busy_o || tag_q.size() != 0 || exp_q.size() != 0); i++)
            @(negedge clk);
        check("drain_busy", 32'(busy_o), 0);
        check("drain_tags_left", 32'(tag_q.size()), 0);
        check("drain_beats_left", 32'(exp_q.size()), 0);
    endtask

    task automatic wait_beats_left(input int n);
        for (int i = 0; i < 100 && exp_q.size() > n; i++) @(negedge clk);
        check("line_progress", 32'(exp_q.size() <= n), 1);
    endtask

    // Source side: handshake sampled on the active edge, queues advanced on the opposite one.
    always @(posedge clk) hs <= s_tvalid_i & s_tready_o;

    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (hs[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
            if (src_q[c].size() > 0) begin
                s_tvalid_i[c]          = 1'b1;
                s_tdata_i[32*c +: 32]  = src_q[c][0].data;
                s_tlast_i[c]           = src_q[c][0].last;
            end else begin
                s_tvalid_i[c]          = 1'b0;
                s_tdata_i[32*c +: 32]  = '0;
                s_tlast_i[c]           = 1'b0;
            end
        end
    end

    // Datapath output monitor.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n) begin
            if (dp_vld_o) begin
                if (exp_q.size() == 0) begin
                    check("dp_unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("dp_pixels", {dp_pixel4_o, dp_pixel3_o, dp_pixel2_o, dp_pixel1_o}, e.data);
                    check("dp_tlast", 32'(dp_tlast_o), 32'(e.last));
                end
                if (chk_gap && gap_armed) check("line_gap_cycles", 32'(idle_cnt), 2);
                gap_armed = dp_tlast_o;
                idle_cnt  = 0;
            end else begin
                idle_cnt++;
            end
        end
    end

    // Datapath model: results emerge LAT cycles after each dp tlast unless held.
    always @(negedge clk) begin
        int t;
        dp_vld_i   = 1'b0;
        dp_tlast_i = 1'b0;
        if (rst_n) begin
            if (dl[LAT-1]) pend++;
            dl = {dl[LAT-2:0], dp_vld_o & dp_tlast_o};
            if (spur || (!hold && pend > 0)) begin
                if (spur) spur = 1'b0;
                else pend--;
                dp_vld_i   = 1'b1;
                dp_tlast_i = 1'b1;
                if (tag_q.size() == 0) begin
                    check("res_tag_vld_empty", 32'(res_tag_vld_o), 0);
                end else begin
                    t = tag_q.pop_front();
                    check("res_tag_vld", 32'(res_tag_vld_o), 1);
                    check("res_ch", 32'(res_ch_o), 32'(t));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #12;
        check("rst_s_tready", 32'(s_tready_o), 0);
        check("rst_dp_vld", 32'(dp_vld_o), 0);
        check("rst_dp_tlast", 32'(dp_tlast_o), 0);
        check("rst_dp_pix", {dp_pixel4_o, dp_pixel3_o, dp_pixel2_o, dp_pixel1_o}, 0);
        check("rst_res_vld", 32'(res_tag_vld_o), 0);
        check("rst_res_ch", 32'(res_ch_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_errs", {30'd0, err_len_o, err_tag_o}, 0);
        check("rst_line_cnt", 32'(line_cnt_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single channel, normal line, with IDLE->ready latency
        send_line(0, 1, LW, LW - 1);
        exp_line(0, 1, 0, LW);
        repeat (2) @(negedge clk);
        check("en_off_no_ready", 32'(s_tready_o), 0);
        en_i = 1'b1;
        @(negedge clk);
        check("arb_no_ready", 32'(s_tready_o), 0);
        @(negedge clk);
        check("stream_ready", 32'(s_tready_o), 32'b01);
        wait_lines(1);
        wait_drain();
        check("single_res_vld_after", 32'(res_tag_vld_o), 0);
        check("single_err_len", 32'(err_len_o), 0);
        check("single_err_tag", 32'(err_tag_o), 0);

        // Round-robin from reset: 0,1,0,1 with two dead cycles between lines
        do_reset();
        chk_gap = 1'b1;
        send_line(0, 1, LW, LW - 1);
        send_line(0, 3, LW, LW - 1);
        send_line(1, 2, LW, LW - 1);
        send_line(1, 4, LW, LW - 1);
        exp_line(0, 1, 0, LW);
        exp_line(1, 2, 0, LW);
        exp_line(0, 3, 0, LW);
        exp_line(1, 4, 0, LW);
        wait_lines(4);
        wait_drain();
        chk_gap = 1'b0;
        check("rr_err_len", 32'(err_len_o), 0);

        // Length errors: early tlast, missing tlast, late tlast starting the next line
        do_reset();
        send_line(0, 5, 6, 5);
        send_line(0, 6, 10, 9);
        exp_line(0, 5, 0, 6);
        exp_line(0, 6, 0, LW);
        exp_line(0, 6, LW, 2);
        wait_lines(1);
        check("early_tlast_err", 32'(err_len_o), 1);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        check("err_len_cleared", 32'(err_len_o), 0);
        wait_lines(2);
        check("forced_tlast_err", 32'(err_len_o), 1);
        wait_lines(3);
        wait_drain();
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        check("err_len_clear_end", 32'(err_len_o), 0);

        // Tag FIFO full blocks arbitration until a result line retires
        do_reset();
        hold = 1'b1;
        send_line(0, 7, LW, LW - 1);
        send_line(1, 8, LW, LW - 1);
        send_line(0, 9, LW, LW - 1);
        exp_line(0, 7, 0, LW);
        exp_line(1, 8, 0, LW);
        exp_line(0, 9, 0, LW);
        wait_lines(2);
        repeat (10) @(negedge clk);
        check("full_no_ready", 32'(s_tready_o), 0);
        check("full_line_cnt", 32'(line_cnt_o), 2);
        check("full_busy", 32'(busy_o), 1);
        hold = 1'b0;
        begin
            int i;
            for (i = 0; i < 8 && s_tready_o == '0; i++) @(negedge clk);
            check("full_release_grant", 32'(i <= 5), 1);
            check("full_release_ch", 32'(s_tready_o), 32'b01);
        end
        wait_lines(3);
        wait_drain();

        // Enable dropped mid-line: line completes, then stays idle
        do_reset();
        send_line(0, 10, LW, LW - 1);
        send_line(1, 11, LW, LW - 1);
        exp_line(0, 10, 0, LW);
        wait_beats_left(LW - 3);
        en_i = 1'b0;
        wait_lines(1);
        repeat (12) @(negedge clk);
        check("en_off_line_cnt", 32'(line_cnt_o), 1);
        check("en_off_ready", 32'(s_tready_o), 0);
        check("en_off_busy", 32'(busy_o), 0);

        // Reset mid-line on ch1: immediate flush, next grant goes to ch0
        exp_line(1, 11, 0, LW);
        en_i = 1'b1;
        wait_beats_left(LW - 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(s_tready_o), 0);
        check("midrst_dp_vld", 32'(dp_vld_o), 0);
        check("midrst_dp_pix", {dp_pixel4_o, dp_pixel3_o, dp_pixel2_o, dp_pixel1_o}, 0);
        check("midrst_busy", 32'(busy_o), 0);
        check("midrst_res_vld", 32'(res_tag_vld_o), 0);
        check("midrst_line_cnt", 32'(line_cnt_o), 0);
        flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_line(1, 12, LW, LW - 1);
        send_line(0, 13, LW, LW - 1);
        exp_line(0, 13, 0, LW);
        exp_line(1, 12, 0, LW);
        wait_lines(2);
        wait_drain();
        check("postrst_err_len", 32'(err_len_o), 0);

        // Spurious result tlast with empty tag FIFO
        spur = 1'b1;
        repeat (3) @(negedge clk);
        check("spur_err_tag", 32'(err_tag_o), 1);
        check("spur_line_cnt", 32'(line_cnt_o), 2);
        check("spur_res_vld", 32'(res_tag_vld_o), 0);
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        check("err_tag_cleared", 32'(err_tag_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
